// File: rtl/timer_irq_ctrl.sv
// Timer expiry handshake and interrupt controller: acknowledges each timer expiry once,
// counts expiries, and tracks pending/overrun interrupt state for the CPU.
module timer_irq_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GWE,
  input  logic             timer_status,
  output logic             timer_read_status,
  input  logic             ctrl_we,
  input  logic [1:0]       ctrl_in,
  input  logic             cpu_ack,
  input  logic             clr_overrun,
  output logic             irq,
  output logic             pending,
  output logic             overrun,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {StIdle, StAck, StWaitClr} state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             event_hit;
  logic             clr_count;

  assign event_hit = GWE && (state_q == StIdle) && timer_status;
  assign clr_count = ctrl_we && ctrl_in[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    irq_en_d  = irq_en_q;
    tick_d    = tick_q;
    if (GWE) begin
      unique case (state_q)
        StIdle:    if (timer_status) state_d = StAck;
        StAck:     state_d = StWaitClr;
        StWaitClr: if (!timer_status) state_d = StIdle;
        default:   state_d = StIdle;
      endcase

      // A coincident cpu_ack retires the old expiry first, so the new one is not an overrun.
      if (event_hit) begin
        pending_d = 1'b1;
      end else if (cpu_ack) begin
        pending_d = 1'b0;
      end

      if (event_hit && pending_q && !cpu_ack) begin
        overrun_d = 1'b1;
      end else if (clr_overrun) begin
        overrun_d = 1'b0;
      end

      if (ctrl_we) irq_en_d = ctrl_in[0];

      // Clear then count: a clear coinciding with an event leaves a count of one.
      if (event_hit) begin
        tick_d = clr_count ? CNT_W'(1) : tick_q + CNT_W'(1);
      end else if (clr_count) begin
        tick_d = '0;
      end
    end
  end

  assign timer_read_status = (state_q == StAck);
  assign irq               = pending_q && irq_en_q;
  assign pending           = pending_q;
  assign overrun           = overrun_q;
  assign tick_count        = tick_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed table-driven bench for timer_irq_ctrl, plus sequences for counter wrap and
// asynchronous reset while acknowledging.
module tb_timer_irq_ctrl;

  localparam int unsigned CntW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic            GWE;
  logic            timer_status;
  logic            timer_read_status;
  logic            ctrl_we;
  logic [1:0]      ctrl_in;
  logic            cpu_ack;
  logic            clr_overrun;
  logic            irq;
  logic            pending;
  logic            overrun;
  logic [CntW-1:0] tick_count;

  int checks = 0;
  int errors = 0;

  timer_irq_ctrl #(.CNT_W(CntW)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .GWE               (GWE),
    .timer_status      (timer_status),
    .timer_read_status (timer_read_status),
    .ctrl_we           (ctrl_we),
    .ctrl_in           (ctrl_in),
    .cpu_ack           (cpu_ack),
    .clr_overrun       (clr_overrun),
    .irq               (irq),
    .pending           (pending),
    .overrun           (overrun),
    .tick_count        (tick_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            gwe;
    logic            ts;
    logic            we;
    logic [1:0]      cin;
    logic            ack;
    logic            clro;
    logic            trs;
    logic            irq;
    logic            pend;
    logic            ovr;
    logic [CntW-1:0] tick;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic gwe, input logic ts, input logic we, input logic [1:0] cin,
                     input logic ack, input logic clro, input logic trs, input logic irq_e,
                     input logic pend, input logic ovr, input logic [CntW-1:0] tick);
    vec_t v;
    v = '{gwe: gwe, ts: ts, we: we, cin: cin, ack: ack, clro: clro, trs: trs, irq: irq_e,
          pend: pend, ovr: ovr, tick: tick};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic gwe, input logic ts, input logic we, input logic [1:0] cin,
                       input logic ack, input logic clro);
    @(negedge CLK);
    GWE = gwe; timer_status = ts; ctrl_we = we; ctrl_in = cin;
    cpu_ack = ack; clr_overrun = clro;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_event();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  function automatic logic [11:0] outs();
    return {timer_read_status, irq, pending, overrun, tick_count};
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0; GWE = 1'b1; timer_status = 1'b0; ctrl_we = 1'b0; ctrl_in = 2'b00;
    cpu_ack = 1'b0; clr_overrun = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    // gwe ts we cin ack clro | trs irq pend ovr tick
    add(1, 0, 1, 2'b01, 0, 0,  0, 0, 0, 0, 8'd0);
    add(1, 1, 0, 2'b00, 0, 0,  1, 1, 1, 0, 8'd1);
    add(1, 1, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd1);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd1);
    add(1, 0, 0, 2'b00, 1, 0,  0, 0, 0, 0, 8'd1);
    add(1, 1, 0, 2'b00, 0, 0,  1, 1, 1, 0, 8'd2);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd2);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd2);
    add(1, 1, 0, 2'b00, 0, 0,  1, 1, 1, 1, 8'd3);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 1, 8'd3);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 1, 8'd3);
    add(1, 0, 0, 2'b00, 1, 1,  0, 0, 0, 0, 8'd3);
    add(1, 1, 0, 2'b00, 0, 0,  1, 1, 1, 0, 8'd4);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd4);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd4);
    add(1, 1, 0, 2'b00, 1, 0,  1, 1, 1, 0, 8'd5);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd5);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 0, 8'd5);
    add(1, 1, 1, 2'b11, 0, 1,  1, 1, 1, 1, 8'd1);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 1, 8'd1);
    add(1, 0, 0, 2'b00, 0, 0,  0, 1, 1, 1, 8'd1);
    add(1, 0, 1, 2'b10, 0, 0,  0, 0, 1, 1, 8'd0);
    add(0, 1, 0, 2'b00, 0, 0,  0, 0, 1, 1, 8'd0);
    add(0, 1, 0, 2'b00, 1, 0,  0, 0, 1, 1, 8'd0);
    add(1, 1, 0, 2'b00, 0, 0,  1, 0, 1, 1, 8'd1);
    add(0, 1, 0, 2'b00, 0, 0,  1, 0, 1, 1, 8'd1);
    add(1, 0, 0, 2'b00, 0, 0,  0, 0, 1, 1, 8'd1);
    add(1, 0, 0, 2'b00, 0, 0,  0, 0, 1, 1, 8'd1);
    add(1, 0, 1, 2'b01, 1, 1,  0, 0, 0, 0, 8'd1);

    // Reset state while RST is held low.
    RST = 1'b0; GWE = 1'b1; timer_status = 1'b1; ctrl_we = 1'b1; ctrl_in = 2'b01;
    cpu_ack = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outs", 32'(outs()), 32'h0);
    apply_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].gwe, vecs[i].ts, vecs[i].we, vecs[i].cin, vecs[i].ack, vecs[i].clro);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].trs, vecs[i].irq, vecs[i].pend, vecs[i].ovr, vecs[i].tick}));
    end

    // Counter wrap at CNT_W=8.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) do_event();
    check("preload_tick", 32'(tick_count), 32'd255);
    check("preload_ovr", 32'(overrun), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    check("wrap_tick", 32'(tick_count), 32'd0);
    check("wrap_trs", 32'(timer_read_status), 32'd1);

    // Async reset while in ACK: outputs drop before the next clock edge.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    check("pre_rst_trs_irq", 32'({timer_read_status, irq}), 32'b11);
    #1 RST = 1'b0;
    #1;
    check("async_rst_outs", 32'(outs()), 32'h0);
    @(negedge CLK);
    RST = 1'b1; timer_status = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_reack", 32'({timer_read_status, tick_count}), 32'({1'b1, 8'd1}));
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      if (timer_read_status) pulses++;
    end
    check("rst_single_ack", 32'(pulses), 32'd1);
    check("rst_tick_hold", 32'(tick_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the tick event counter; legal range 8..32.
REQ-002 Port: CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous and active-low.
REQ-004 Port: GWE  input  1  global write enable; no register changes in a cycle where GWE=0.
REQ-005 Port: timer_status  input  1  expiry flag from the timer device (bit 31 of its counter).
REQ-006 Port: timer_read_status  output  1  acknowledge to the timer device; 1 for exactly one enabled cycle per expiry.
REQ-007 Port: ctrl_we  input  1  CPU write strobe for the control register.
REQ-008 Port: ctrl_in  input  2  [0]=irq_en, [1]=clr_count.
REQ-009 Port: cpu_ack  input  1  CPU clears the pending flag.
REQ-010 Port: clr_overrun  input  1  CPU clears the sticky overrun flag.
REQ-011 Port: irq  output  1  interrupt request = pending AND irq_en.
REQ-012 Port: pending  output  1  unacknowledged expiry present.
REQ-013 Port: overrun  output  1  sticky flag: an expiry arrived while pending was already 1.
REQ-014 Port: tick_count  output  CNT_W  number of expiries handled, modulo 2^CNT_W.

Function
REQ-015 The FSM SHALL have the states IDLE, ACK and WAIT_CLR, encoded in registers, advancing only when GWE=1.
REQ-016 IDLE -> ACK SHALL occur when timer_status=1; otherwise the FSM stays in IDLE.
REQ-017 ACK -> WAIT_CLR SHALL occur unconditionally after one enabled cycle.
REQ-018 WAIT_CLR -> IDLE SHALL occur when timer_status=0; the FSM stays in WAIT_CLR while timer_status=1, so no double acknowledge is issued.
REQ-019 timer_read_status SHALL be registered-state decoded: 1 iff state=ACK.
REQ-020 On the IDLE->ACK transition ("event"), tick_count SHALL increment by 1, wrapping from 2^CNT_W-1 to 0 without a flag.
REQ-021 On an event, pending SHALL be set to 1; if pending was already 1, overrun SHALL be set to 1.
REQ-022 cpu_ack=1 SHALL clear pending; when it coincides with an event, the event wins: pending stays 1 and overrun is not set.
REQ-023 clr_overrun=1 SHALL clear overrun; when it coincides with an overrun-setting event, overrun stays 1.
REQ-024 A ctrl_we write SHALL load irq_en from ctrl_in[0]; ctrl_in[1]=1 SHALL zero tick_count. When the write coincides with an event, tick_count becomes 1.
REQ-025 irq SHALL be combinational from the registered pending and irq_en; an event raises irq one cycle after the event edge.
REQ-026 Latency: timer_status rising while in IDLE SHALL produce timer_read_status=1 on the next enabled cycle.
REQ-027 With GWE=0, all state and outputs SHALL hold; timer_read_status SHALL remain at its held value.

Reset
REQ-028 While RST=0, the block SHALL immediately force state=IDLE, pending=0, overrun=0, irq_en=0, tick_count=0, timer_read_status=0 and irq=0, independent of CLK.
REQ-029 Reset deassertion mid-operation (including in ACK) SHALL restart from IDLE; an expiry whose status is still high is then acknowledged normally.

Verification
REQ-030 Reset, GWE=1, irq_en=1, pulse timer_status high and model the timer reload (drop 1 cycle after ack) -> timer_read_status=1 for 1 cycle, tick_count=1, pending=1, irq=1.
REQ-031 Hold timer_status=1 for 5 cycles after the ack -> exactly one timer_read_status pulse; the FSM stays in WAIT_CLR; tick_count increments by 1 only.
REQ-032 Two expiries without cpu_ack -> overrun=1, tick_count=2; then clr_overrun and cpu_ack -> overrun=0, pending=0, irq=0.
REQ-033 cpu_ack in the same cycle as an event -> pending=1, overrun=0; ctrl_we with ctrl_in=2'b10 in the same cycle as an event -> tick_count=1.
REQ-034 CNT_W=8, preload 255 events -> the next event gives tick_count=0; GWE=0 during an expiry -> no ack and no state change until GWE=1.
REQ-035 Assert RST=0 asynchronously while in ACK -> all outputs are 0 before the next CLK edge; after release with timer_status=1 -> a single new ack is issued.
